// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end. Issues one word request at a time
// to instruction memory, queues returned words with their byte address in a
// two-entry FIFO, and handles branch redirects and jumps, including dropping
// a response that is still in flight when the target changes.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [11:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        jump,
  input  logic [25:0] jump_adr,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] fetch_pc
);

  // DISCARD means the outstanding response belongs to an abandoned path.
  typedef enum logic {FETCH = 1'b0, DISCARD = 1'b1} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic        req_reg, req_next;
  logic [11:0] addr_reg, addr_next;
  logic [1:0]  count_reg, count_next;
  logic        rd_ptr_reg, rd_ptr_next;
  logic        wr_ptr_reg, wr_ptr_next;

  logic [31:0] pc_mem   [0:1];
  logic [31:0] word_mem [0:1];

  logic flush;
  logic ack_ok;
  logic push;
  logic pop;
  logic busy_after;
  logic issue;

  // Target addresses are word aligned, so the low branch-target bits carry nothing.
  logic unused_ok;
  assign unused_ok = &{1'b0, redirect_pc[1:0]};

  // Next-state, queue bookkeeping and request issue decision.
  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    count_next  = count_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;

    flush      = redirect | jump;
    // An ack only means something while a request is actually outstanding.
    ack_ok     = imem_ack & req_reg;
    pop        = (count_reg != 2'd0) & ~stall & ~flush;
    push       = ack_ok & (state_reg == FETCH) & ~flush;
    busy_after = req_reg & ~imem_ack;

    if (redirect) begin
      pc_next = {redirect_pc[31:2], 2'b00};
    end else if (jump) begin
      pc_next = {pc_reg[31:28], jump_adr, 2'b00};
    end else if (push) begin
      pc_next = pc_reg + 32'd4;
    end

    if (flush) begin
      count_next  = 2'd0;
      rd_ptr_next = 1'b0;
      wr_ptr_next = 1'b0;
    end else begin
      count_next  = count_reg + {1'b0, push} - {1'b0, pop};
      rd_ptr_next = rd_ptr_reg ^ pop;
      wr_ptr_next = wr_ptr_reg ^ push;
    end

    // A still-pending request after a target change must be thrown away.
    if (flush) begin
      state_next = busy_after ? DISCARD : FETCH;
    end else if ((state_reg == DISCARD) && ack_ok) begin
      state_next = FETCH;
    end

    // Slots left after this edge (queued plus in flight) decide a new request.
    issue     = ~busy_after & (int'(count_next) < QDEPTH);
    req_next  = busy_after | issue;
    // Address is frozen while a request waits for its ack.
    addr_next = busy_after ? addr_reg : pc_next[13:2];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Fetch pointer, request handshake and queue control registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_reg     <= RESET_PC;
      req_reg    <= 1'b0;
      addr_reg   <= RESET_PC[13:2];
      count_reg  <= 2'd0;
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
    end else begin
      pc_reg     <= pc_next;
      req_reg    <= req_next;
      addr_reg   <= addr_next;
      count_reg  <= count_next;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
    end
  end

  // Queue storage; contents only matter where the count says they are valid.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      pc_mem[wr_ptr_reg]   <= pc_reg;
      word_mem[wr_ptr_reg] <= imem_rdata;
    end
  end

  assign imem_req   = req_reg;
  assign imem_addr  = addr_reg;
  assign fetch_pc   = pc_reg;
  assign inst_valid = (count_reg != 2'd0);
  // Zero the head when empty so nothing stale is ever visible.
  assign inst       = inst_valid ? word_mem[rd_ptr_reg] : 32'd0;
  assign inst_pc    = inst_valid ? pc_mem[rd_ptr_reg]   : 32'd0;

endmodule
